// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// NOP control-field values seen by the IR / DOF->EX consumers, default widths.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    localparam int DEF_REG_ADDR_WIDTH = 3;
    localparam int DEF_CNT_WIDTH      = 16;

    // Control fields a bubbled DOF->EX register carries (no write, no memory
    // write, no branch, no output enable).
    localparam logic       NOP_RW = 1'b0;
    localparam logic       NOP_MW = 1'b0;
    localparam logic [1:0] NOP_BS = 2'b00;
    localparam logic       NOP_OE = 1'b0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: operand/destination status
// from DOF/EX/WB, run control, and the load/flush/bubble decisions + counters.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
);
    logic [REG_ADDR_WIDTH-1:0] dof_aa;
    logic [REG_ADDR_WIDTH-1:0] dof_ba;
    logic                      dof_use_a;
    logic                      dof_use_b;
    logic                      ex_rw;
    logic [REG_ADDR_WIDTH-1:0] ex_da;
    logic                      wb_rw;
    logic [REG_ADDR_WIDTH-1:0] wb_da;
    logic                      ex_branch_taken;
    logic                      halt_req;
    logic                      step;
    logic                      clear_cnt;

    logic                      pc_load_en;
    logic                      pc_sel_branch;
    logic                      ir_load_en;
    logic                      ir_flush;
    logic                      dof_bubble;
    logic                      halted;
    logic [CNT_WIDTH-1:0]      issue_cnt;
    logic [CNT_WIDTH-1:0]      stall_cnt;
    logic [CNT_WIDTH-1:0]      flush_cnt;

    // Pipeline / debug host side.
    modport master (
        output dof_aa, dof_ba, dof_use_a, dof_use_b, ex_rw, ex_da, wb_rw, wb_da,
               ex_branch_taken, halt_req, step, clear_cnt,
        input  pc_load_en, pc_sel_branch, ir_load_en, ir_flush, dof_bubble,
               halted, issue_cnt, stall_cnt, flush_cnt
    );

    // Controller side.
    modport slave (
        input  dof_aa, dof_ba, dof_use_a, dof_use_b, ex_rw, ex_da, wb_rw, wb_da,
               ex_branch_taken, halt_req, step, clear_cnt,
        output pc_load_en, pc_sel_branch, ir_load_en, ir_flush, dof_bubble,
               halted, issue_cnt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ALL_ONE = '1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != ALL_ONE)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall detection against EX/WB writers,
// taken-branch squash, halt/single-step run control and debug counters.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | free running; issues whenever no hazard
//   ST_HALT | fetch/issue frozen, EX/WB drain; step may grant one issue
//   ST_STEP | one instruction pending; back to HALT on its issue cycle
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int START_RUNNING  = 1,
    parameter int R0_HARDWIRED   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO   = '0;
    localparam bit                        R0_EN       = (R0_HARDWIRED != 0);
    localparam state_e                    RESET_STATE = (START_RUNNING != 0) ? ST_RUN : ST_HALT;

    state_e state_q;
    state_e state_d;

    logic hazard_a;
    logic hazard_b;
    logic hazard;
    logic issue;
    logic inc_issue;
    logic inc_stall;
    logic inc_flush;
    logic pc_load_en;
    logic pc_sel_branch;
    logic ir_load_en;
    logic ir_flush;
    logic dof_bubble;

    logic [CNT_WIDTH-1:0] issue_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    // RAW hazard: a read source matches a pending EX or WB write (R0 optionally exempt).
    always_comb begin
        hazard_a = bus.dof_use_a && !(R0_EN && (bus.dof_aa == ADDR_ZERO)) &&
                   ((bus.ex_rw && (bus.ex_da == bus.dof_aa)) ||
                    (bus.wb_rw && (bus.wb_da == bus.dof_aa)));
        hazard_b = bus.dof_use_b && !(R0_EN && (bus.dof_ba == ADDR_ZERO)) &&
                   ((bus.ex_rw && (bus.ex_da == bus.dof_ba)) ||
                    (bus.wb_rw && (bus.wb_da == bus.dof_ba)));
        hazard   = hazard_a || hazard_b;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-cycle priority (branch > halt > hazard > issue) and next state.
    always_comb begin
        pc_load_en    = 1'b0;
        pc_sel_branch = 1'b0;
        ir_load_en    = 1'b0;
        ir_flush      = 1'b0;
        dof_bubble    = 1'b1;
        issue         = 1'b0;
        inc_issue     = 1'b0;
        inc_stall     = 1'b0;
        inc_flush     = 1'b0;
        state_d       = state_q;

        if (bus.ex_branch_taken) begin
            pc_load_en    = 1'b1;
            pc_sel_branch = 1'b1;
            ir_load_en    = 1'b1;
            ir_flush      = 1'b1;
            inc_flush     = 1'b1;
        end else if (state_q == ST_HALT) begin
            dof_bubble = 1'b1;
        end else if (hazard) begin
            inc_stall = 1'b1;
        end else begin
            pc_load_en = 1'b1;
            ir_load_en = 1'b1;
            dof_bubble = 1'b0;
            issue      = 1'b1;
            inc_issue  = 1'b1;
        end

        // A flush cycle never moves the FSM, so a pending step survives it.
        if (!bus.ex_branch_taken) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.halt_req) state_d = ST_HALT;
                end
                ST_HALT: begin
                    if (!bus.halt_req)  state_d = ST_RUN;
                    else if (bus.step)  state_d = ST_STEP;
                end
                ST_STEP: begin
                    if (issue) state_d = ST_HALT;
                end
                default: state_d = RESET_STATE;
            endcase
        end

        // Reset holds the pipeline frozen with a NOP in IR and a bubble into EX.
        if (reset) begin
            pc_load_en    = 1'b0;
            pc_sel_branch = 1'b0;
            ir_load_en    = 1'b0;
            ir_flush      = 1'b1;
            dof_bubble    = 1'b1;
            inc_issue     = 1'b0;
            inc_stall     = 1'b0;
            inc_flush     = 1'b0;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_issue_cnt (
        .clk (clk),
        .rst (reset),
        .clr (bus.clear_cnt),
        .inc (inc_issue),
        .cnt (issue_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk (clk),
        .rst (reset),
        .clr (bus.clear_cnt),
        .inc (inc_stall),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk (clk),
        .rst (reset),
        .clr (bus.clear_cnt),
        .inc (inc_flush),
        .cnt (flush_cnt)
    );

    assign bus.pc_load_en    = pc_load_en;
    assign bus.pc_sel_branch = pc_sel_branch;
    assign bus.ir_load_en    = ir_load_en;
    assign bus.ir_flush      = ir_flush;
    assign bus.dof_bubble    = dof_bubble;
    assign bus.halted        = (state_q == ST_HALT);
    assign bus.issue_cnt     = issue_cnt;
    assign bus.stall_cnt     = stall_cnt;
    assign bus.flush_cnt     = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// compared against a rule-level model of issue/stall/flush and run control.
module tb_pipeline_hazard_ctrl;

    localparam int P_AW    = 3;
    localparam int P_CW    = 16;
    localparam int P_START = 1;
    localparam int P_R0    = 0;
    localparam int CNT_MAX = (1 << P_CW) - 1;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(P_AW), .CNT_WIDTH(P_CW)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_WIDTH (P_AW),
        .CNT_WIDTH      (P_CW),
        .START_RUNNING  (P_START),
        .R0_HARDWIRED   (P_R0)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: run mode as two flags plus plain integer counters.
    bit m_halt;
    bit m_step;
    int m_issue;
    int m_stall;
    int m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit src_hazard(input bit use_src, input int addr);
        bit hit;
        hit = (bus.ex_rw && int'(bus.ex_da) == addr) || (bus.wb_rw && int'(bus.wb_da) == addr);
        if (P_R0 != 0 && addr == 0) hit = 1'b0;
        return use_src && hit;
    endfunction

    function automatic int bump(input int v, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && v < CNT_MAX) return v + 1;
        return v;
    endfunction

    task automatic model_reset();
        m_halt  = (P_START == 0);
        m_step  = 1'b0;
        m_issue = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic set_idle();
        bus.dof_aa = '0; bus.dof_ba = '0; bus.dof_use_a = 1'b0; bus.dof_use_b = 1'b0;
        bus.ex_rw = 1'b0; bus.ex_da = '0; bus.wb_rw = 1'b0; bus.wb_da = '0;
        bus.ex_branch_taken = 1'b0; bus.step = 1'b0; bus.clear_cnt = 1'b0;
    endtask

    task automatic chk_forced();
        chk("rst_pc_load", 32'(bus.pc_load_en), 0);
        chk("rst_ir_load", 32'(bus.ir_load_en), 0);
        chk("rst_ir_flush", 32'(bus.ir_flush), 1);
        chk("rst_bubble", 32'(bus.dof_bubble), 1);
        chk("rst_pc_sel", 32'(bus.pc_sel_branch), 0);
        chk("rst_issue_cnt", 32'(bus.issue_cnt), 0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 0);
        chk("rst_flush_cnt", 32'(bus.flush_cnt), 0);
    endtask

    task automatic chk_counters();
        chk("issue_cnt", 32'(bus.issue_cnt), 32'(m_issue));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
    endtask

    // One clock: check Mealy outputs at negedge, advance model, check counters after the edge.
    task automatic run_cycle(input bit do_check);
        bit hz, br, iss, stl;
        bit e_pc, e_sel, e_ir, e_fl, e_bub;
        @(negedge clk);
        hz  = src_hazard(bus.dof_use_a, int'(bus.dof_aa)) || src_hazard(bus.dof_use_b, int'(bus.dof_ba));
        br  = bus.ex_branch_taken;
        iss = 1'b0; stl = 1'b0;
        e_pc = 1'b0; e_sel = 1'b0; e_ir = 1'b0; e_fl = 1'b0; e_bub = 1'b1;
        if (br) begin
            e_pc = 1'b1; e_sel = 1'b1; e_ir = 1'b1; e_fl = 1'b1;
        end else if (m_halt) begin
            e_bub = 1'b1;
        end else if (hz) begin
            stl = 1'b1;
        end else begin
            e_pc = 1'b1; e_ir = 1'b1; e_bub = 1'b0; iss = 1'b1;
        end
        if (do_check) begin
            chk("pc_load_en", 32'(bus.pc_load_en), 32'(e_pc));
            chk("pc_sel_branch", 32'(bus.pc_sel_branch), 32'(e_sel));
            chk("ir_load_en", 32'(bus.ir_load_en), 32'(e_ir));
            chk("ir_flush", 32'(bus.ir_flush), 32'(e_fl));
            chk("dof_bubble", 32'(bus.dof_bubble), 32'(e_bub));
            chk("halted", 32'(bus.halted), 32'(m_halt));
        end
        m_issue = bump(m_issue, iss, bus.clear_cnt);
        m_stall = bump(m_stall, stl, bus.clear_cnt);
        m_flush = bump(m_flush, br, bus.clear_cnt);
        if (!br) begin
            if (m_halt) begin
                if (!bus.halt_req) m_halt = 1'b0;
                else if (bus.step) begin m_halt = 1'b0; m_step = 1'b1; end
            end else if (m_step) begin
                if (iss) begin m_step = 1'b0; m_halt = 1'b1; end
            end else if (bus.halt_req) begin
                m_halt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (do_check) chk_counters();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.halt_req = 1'b0;
        set_idle();
        model_reset();
        #3;
        chk_forced();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Independent stream.
        repeat (10) run_cycle(1);
        chk("t1_issue", 32'(bus.issue_cnt), 10);
        chk("t1_stall", 32'(bus.stall_cnt), 0);

        // Back-to-back dependency: producer in EX, then WB, then released.
        bus.ex_rw = 1'b1; bus.ex_da = 3'd3; bus.dof_use_a = 1'b1; bus.dof_aa = 3'd3;
        run_cycle(1);
        bus.ex_rw = 1'b0; bus.wb_rw = 1'b1; bus.wb_da = 3'd3;
        run_cycle(1);
        bus.wb_rw = 1'b0;
        run_cycle(1);
        chk("t2_stall", 32'(bus.stall_cnt), 2);
        chk("t2_issue", 32'(bus.issue_cnt), 11);

        // Branch taken while a hazard is present.
        set_idle();
        bus.ex_rw = 1'b1; bus.ex_da = 3'd5; bus.dof_use_b = 1'b1; bus.dof_ba = 3'd5;
        bus.ex_branch_taken = 1'b1;
        run_cycle(1);
        chk("t3_flush", 32'(bus.flush_cnt), 1);
        chk("t3_stall", 32'(bus.stall_cnt), 2);

        // Halt, then single step through one stall cycle.
        set_idle();
        bus.halt_req = 1'b1;
        run_cycle(1);
        run_cycle(1);
        bus.step = 1'b1;
        run_cycle(1);
        bus.step = 1'b0;
        bus.ex_rw = 1'b1; bus.ex_da = 3'd2; bus.dof_use_a = 1'b1; bus.dof_aa = 3'd2;
        run_cycle(1);
        set_idle();
        run_cycle(1);
        run_cycle(1);
        chk("t4_halted", 32'(bus.halted), 1);
        chk("t4_issue", 32'(bus.issue_cnt), 13);

        // Saturate stall_cnt under a sustained hazard, then clear during a stall.
        bus.halt_req = 1'b0;
        run_cycle(1);
        bus.ex_rw = 1'b1; bus.ex_da = 3'd4; bus.dof_use_a = 1'b1; bus.dof_aa = 3'd4;
        repeat (CNT_MAX + 4) run_cycle(0);
        chk("t5_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));
        run_cycle(1);
        chk("t5_hold", 32'(bus.stall_cnt), 32'(CNT_MAX));
        bus.clear_cnt = 1'b1;
        run_cycle(1);
        bus.clear_cnt = 1'b0;
        chk("t5_clear", 32'(bus.stall_cnt), 0);

        // Random traffic.
        set_idle();
        for (int i = 0; i < 3000; i++) begin
            bus.dof_aa          = P_AW'($urandom_range(7));
            bus.dof_ba          = P_AW'($urandom_range(7));
            bus.dof_use_a       = ($urandom_range(1) == 1);
            bus.dof_use_b       = ($urandom_range(1) == 1);
            bus.ex_rw           = ($urandom_range(2) == 0);
            bus.ex_da           = P_AW'($urandom_range(7));
            bus.wb_rw           = ($urandom_range(2) == 0);
            bus.wb_da           = P_AW'($urandom_range(7));
            bus.ex_branch_taken = ($urandom_range(7) == 0);
            bus.step            = ($urandom_range(5) == 0);
            bus.clear_cnt       = ($urandom_range(49) == 0);
            if ($urandom_range(15) == 0) bus.halt_req = ~bus.halt_req;
            run_cycle(1);
        end

        // Async reset in STEP while stalled.
        set_idle();
        bus.halt_req = 1'b1;
        run_cycle(1);
        run_cycle(1);
        bus.step = 1'b1;
        run_cycle(1);
        bus.step = 1'b0;
        bus.ex_rw = 1'b1; bus.ex_da = 3'd1; bus.dof_use_a = 1'b1; bus.dof_aa = 3'd1;
        run_cycle(1);
        #2;
        reset = 1'b1;
        #1;
        chk_forced();
        model_reset();
        @(posedge clk);
        #1;
        chk_forced();
        reset = 1'b0;
        set_idle();
        bus.halt_req = 1'b0;
        chk("t6_halted", 32'(bus.halted), 32'(P_START == 0));
        run_cycle(1);
        run_cycle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
